// File: rtl/fc_layer_serial_sched.sv
// fc_layer_serial_sched
//   Time-multiplexed fully connected layer. One shared signed MAC sequences
//   through all OUT_SIZE neurons in turn. Each neuron takes one LOAD cycle
//   (bias), IN_SIZE MAC cycles and one WRITE cycle (ReLU with saturation).
//
// Ports
//   clk              clock, all logic on posedge
//   reset            synchronous active-low reset
//   start            request an evaluation; sampled only while idle
//   in_vector_flat   IN_SIZE signed W-bit inputs, element i at [i*W +: W]
//   weights_flat     OUT_SIZE rows of IN_SIZE signed W-bit weights
//   biases_flat      OUT_SIZE signed W-bit biases
//   out_vector_flat  OUT_SIZE W-bit outputs (registered)
//   busy             high while an evaluation is in progress
//   done             level, high from completion until next accept or reset
//
// Inputs are read live during the evaluation and must be held stable from
// the accept edge until done rises.
module fc_layer_serial_sched #(
    parameter int IN_SIZE   = 16,
    parameter int OUT_SIZE  = 10,
    parameter int W         = 8,
    parameter int ACC_WIDTH = 2*W+5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [W*IN_SIZE-1:0]         in_vector_flat,
    input  logic [W*OUT_SIZE*IN_SIZE-1:0] weights_flat,
    input  logic [W*OUT_SIZE-1:0]        biases_flat,
    output logic [W*OUT_SIZE-1:0]        out_vector_flat,
    output logic                         busy,
    output logic                         done
);

    localparam int IW = (IN_SIZE  > 1) ? $clog2(IN_SIZE)  : 1;
    localparam int NW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(IN_SIZE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(OUT_SIZE - 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = '0;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'((1 << (W-1)) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MAC   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                      state;
    logic [IW-1:0]               i_idx;
    logic [NW-1:0]               n_idx;
    logic signed [ACC_WIDTH-1:0] acc;

    // Unpacked views of the flattened buses so the shared datapath can
    // select operands by index.
    logic signed [W-1:0] x_arr [IN_SIZE];
    logic signed [W-1:0] w_arr [OUT_SIZE][IN_SIZE];
    logic signed [W-1:0] b_arr [OUT_SIZE];
    logic        [W-1:0] out_arr [OUT_SIZE];

    genvar gi, gn;
    generate
        for (gi = 0; gi < IN_SIZE; gi++) begin : g_x
            assign x_arr[gi] = in_vector_flat[gi*W +: W];
        end
        for (gn = 0; gn < OUT_SIZE; gn++) begin : g_n
            assign b_arr[gn] = biases_flat[gn*W +: W];
            assign out_vector_flat[gn*W +: W] = out_arr[gn];
            for (gi = 0; gi < IN_SIZE; gi++) begin : g_w
                assign w_arr[gn][gi] = weights_flat[(gn*IN_SIZE + gi)*W +: W];
            end
        end
    endgenerate

    logic signed [W-1:0]   x_sel;
    logic signed [W-1:0]   w_sel;
    logic signed [W-1:0]   b_sel;
    logic signed [2*W-1:0] prod;
    logic        [W-1:0]   relu_val;

    assign x_sel = x_arr[i_idx];
    assign w_sel = w_arr[n_idx][i_idx];
    assign b_sel = b_arr[n_idx];
    assign prod  = x_sel * w_sel;   // full-width signed product

    // ReLU with saturation to the largest positive W-bit value; no shift.
    always_comb begin
        // NOTE: default first so every path assigns relu_val and no latch is inferred.
        relu_val = '0;
        if (acc <= ACC_ZERO)
            relu_val = '0;
        else if (acc > SAT_MAX)
            relu_val = SAT_MAX[W-1:0];
        else
            relu_val = acc[W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            n_idx <= '0;
            i_idx <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            // NOTE: the output array is a small bank of flops (not RAM), and
            // it must read 0 after reset, so it is cleared explicitly.
            for (int k = 0; k < OUT_SIZE; k++) out_arr[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        n_idx <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        for (int k = 0; k < OUT_SIZE; k++) out_arr[k] <= '0;
                    end
                end
                LOAD: begin
                    acc   <= ACC_WIDTH'(b_sel);   // sign-extended bias
                    i_idx <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc   <= acc + ACC_WIDTH'(prod);
                    i_idx <= i_idx + 1'b1;
                    if (i_idx == I_LAST) state <= WRITE;
                end
                WRITE: begin
                    out_arr[n_idx] <= relu_val;
                    if (n_idx == N_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        n_idx <= n_idx + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_serial_sched.sv
// Directed bench for fc_layer_serial_sched with default parameters.
module tb_fc_layer_serial_sched;

    localparam int IN_SIZE  = 16;
    localparam int OUT_SIZE = 10;
    localparam int W        = 8;
    localparam int OW       = W*OUT_SIZE;
    localparam int LAT      = OUT_SIZE*(IN_SIZE+2);   // 180

    logic                          clk = 1'b0;
    logic                          reset = 1'b0;
    logic                          start = 1'b0;
    logic [W*IN_SIZE-1:0]          in_vector_flat = '0;
    logic [W*OUT_SIZE*IN_SIZE-1:0] weights_flat = '0;
    logic [W*OUT_SIZE-1:0]         biases_flat = '0;
    logic [OW-1:0]                 out_vector_flat;
    logic                          busy;
    logic                          done;

    int checks   = 0;
    int failures = 0;

    fc_layer_serial_sched #(
        .IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .ACC_WIDTH(2*W+5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_vector_flat(in_vector_flat),
        .weights_flat(weights_flat),
        .biases_flat(biases_flat),
        .out_vector_flat(out_vector_flat),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_uniform(input logic [W-1:0] x, input logic [W-1:0] w,
                               input logic [W-1:0] b);
        for (int i = 0; i < IN_SIZE; i++) in_vector_flat[i*W +: W] = x;
        for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) weights_flat[k*W +: W] = w;
        for (int n = 0; n < OUT_SIZE; n++) biases_flat[n*W +: W] = b;
    endtask

    function automatic logic [OW-1:0] all_out(input logic [W-1:0] v);
        logic [OW-1:0] r;
        for (int n = 0; n < OUT_SIZE; n++) r[n*W +: W] = v;
        return r;
    endfunction

    // Called at a negedge. Accepts start on the next posedge (E0), then counts
    // edges after E0 until done is seen, optionally pulsing start at two counts.
    task automatic run_eval(input int pulse_a, input int pulse_b,
                            output int cycles, output logic [OW-1:0] snap18,
                            output logic busy_e0, output logic done_e0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        busy_e0 = busy;
        done_e0 = done;
        cycles  = 0;
        snap18  = '0;
        while (!done && cycles < 400) begin
            start = (cycles == pulse_a || cycles == pulse_b);
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (cycles == 18) snap18 = out_vector_flat;
        end
        start = 1'b0;
    endtask

    int            cyc;
    logic [OW-1:0] snap;
    logic          b0, d0;
    logic [OW-1:0] exp_relu;

    initial begin
        // Reset with start held high: nothing accepted.
        reset = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out",  out_vector_flat, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Basic: all ones, zero bias -> every output 16.
        set_uniform(8'd1, 8'd1, 8'd0);
        run_eval(-1, -1, cyc, snap, b0, d0);
        check("basic_busy_e0", b0, 1'b1);
        check("basic_cycles", cyc, LAT);
        check("basic_out0_at18", snap[0 +: W], 8'd16);
        check("basic_out1_at18", snap[W +: W], 8'd0);
        check("basic_out", out_vector_flat, all_out(8'd16));
        check("basic_busy_end", busy, 1'b0);

        // ReLU/bias: x=2, w=-1, bias[n]=n+40, bias[3]=10 -> n+8, out[3]=0.
        set_uniform(8'd2, 8'hFF, 8'd0);
        for (int n = 0; n < OUT_SIZE; n++) begin
            biases_flat[n*W +: W] = (n == 3) ? 8'd10 : 8'(n + 40);
            exp_relu[n*W +: W]    = (n == 3) ? 8'd0  : 8'(n + 8);
        end
        run_eval(-1, -1, cyc, snap, b0, d0);
        check("relu_cycles", cyc, LAT);
        check("relu_out", out_vector_flat, exp_relu);

        // Positive saturation: 16*127*127+127 = 258191 -> 127.
        set_uniform(8'd127, 8'd127, 8'd127);
        run_eval(-1, -1, cyc, snap, b0, d0);
        check("satp_out", out_vector_flat, all_out(8'd127));

        // Large negative sum -> 0.
        set_uniform(8'h80, 8'd127, 8'd127);
        run_eval(-1, -1, cyc, snap, b0, d0);
        check("satn_out", out_vector_flat, all_out(8'd0));

        // Start pulses while busy are ignored; single done at 180.
        set_uniform(8'd1, 8'd1, 8'd0);
        run_eval(5, 90, cyc, snap, b0, d0);
        check("ignore_cycles", cyc, LAT);
        check("ignore_out", out_vector_flat, all_out(8'd16));

        // Re-accept on the done-rise cycle: done drops, busy rises.
        run_eval(-1, -1, cyc, snap, b0, d0);
        check("reacc_busy", b0, 1'b1);
        check("reacc_done", d0, 1'b0);
        check("reacc_cycles", cyc, LAT);
        check("reacc_out", out_vector_flat, all_out(8'd16));

        // Mid-operation reset at cycle 50 after accept.
        set_uniform(8'd1, 8'd1, 8'd0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("mid_pre_out0", out_vector_flat[0 +: W], 8'd16);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("mid_out",  out_vector_flat, '0);
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_idle_busy", busy, 1'b0);
        run_eval(-1, -1, cyc, snap, b0, d0);
        check("post_cycles", cyc, LAT);
        check("post_out", out_vector_flat, all_out(8'd16));
        check("post_done", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
